// File: rtl/gateway_route_arbiter_pkg.sv
// Shared types for the route-validation arbiter: route layout, capability
// table entry, FSM encoding and the accept rule.
package lynxTypes;

    localparam int ID_W       = 4;
    localparam int ROUTE_W    = 14;
    localparam int DEST_LSB   = 10;
    localparam int SENDER_LSB = 6;

    typedef struct packed {
        logic [ID_W-1:0]              dest_id;
        logic [ID_W-1:0]              sender_id;
        logic [ROUTE_W-2*ID_W-1:0]    tag;
    } route_t;

    typedef struct packed {
        logic            en;
        logic [ID_W-1:0] sender;
    } cap_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RESP
    } arb_state_t;

    // Sender 0 is a wildcard on either side of the comparison.
    function automatic logic cap_allows(cap_entry_t e, logic [ID_W-1:0] sender);
        return e.en && (e.sender == '0 || e.sender == sender || sender == '0);
    endfunction

endpackage

// File: rtl/gateway_route_arbiter_if.sv
// Request/response bundle between the receive queues, the arbiter and the
// vIO Switch consumer.
interface gateway_route_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*14-1:0] req_route;
    logic [N_REQ-1:0]    req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [SRC_W-1:0]    rsp_src;
    logic [13:0]         rsp_route;
    logic [3:0]          rsp_dest;
    logic                rsp_accept;

    modport master (
        output req_valid, req_route, rsp_ready,
        input  req_ready, rsp_valid, rsp_src, rsp_route, rsp_dest, rsp_accept
    );

    modport slave (
        input  req_valid, req_route, rsp_ready,
        output req_ready, rsp_valid, rsp_src, rsp_route, rsp_dest, rsp_accept
    );

endinterface

// File: rtl/gateway_route_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);

    always_comb begin
        int   p;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        p     = 0;
        for (int k = 0; k < N; k++) begin
            p = (int'(ptr) + k) % N;
            if (!found && req[p]) begin
                found    = 1'b1;
                grant[p] = 1'b1;
                idx      = ($clog2(N))'(p);
            end
        end
    end

endmodule

// File: rtl/gateway_route_arbiter.sv
// Round-robin route checker: one capability lookup in flight at a time,
// verdict held until the consumer takes it.
module gateway_route_arbiter
    import lynxTypes::*;
#(
    parameter int N_REQ   = 4,
    parameter int N_DESTS = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cfg_we,
    input  logic [3:0]              cfg_dest,
    input  logic [3:0]              cfg_sender,
    input  logic                    cfg_en,
    gateway_route_arbiter_if.slave  bus,
    output logic [31:0]             stat_deny_cnt
);

    localparam int SRC_W = $clog2(N_REQ);

    arb_state_t       state, state_nxt;
    logic [SRC_W-1:0] rr_ptr;
    logic [N_REQ-1:0] grant;
    logic [SRC_W-1:0] win_idx;
    route_t           win_route;
    cap_entry_t       cap_tbl [N_DESTS];
    cap_entry_t       rd_entry;
    logic [3:0]       lat_dest;
    logic [3:0]       lat_sender;
    logic             verdict;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    assign win_route    = route_t'(bus.req_route[int'(win_idx)*ROUTE_W +: ROUTE_W]);
    assign lat_dest     = bus.rsp_route[DEST_LSB +: ID_W];
    assign lat_sender   = bus.rsp_route[SENDER_LSB +: ID_W];
    assign bus.rsp_dest = lat_dest;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Grant is gated by reset so req_ready reads 0 while the block is held.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (aresetn) bus.req_ready = grant;
                if (|bus.req_valid) state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: state_nxt = ST_RESP;
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_entry = '0;
        for (int d = 0; d < N_DESTS; d++) begin
            if (lat_dest == 4'(d)) rd_entry = cap_tbl[d];
        end
        verdict = (int'(lat_dest) < N_DESTS) && cap_allows(rd_entry, lat_sender);
    end

    // A write landing in the LOOKUP cycle updates the table on the same edge
    // the verdict is registered, so the verdict still sees the old entry.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int d = 0; d < N_DESTS; d++) cap_tbl[d] <= '0;
        end else if (cfg_we) begin
            for (int d = 0; d < N_DESTS; d++) begin
                if (cfg_dest == 4'(d)) cap_tbl[d] <= '{en: cfg_en, sender: cfg_sender};
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr         <= '0;
            bus.rsp_src    <= '0;
            bus.rsp_route  <= '0;
            bus.rsp_accept <= 1'b0;
            stat_deny_cnt  <= '0;
        end else begin
            if (state == ST_IDLE && |bus.req_valid) begin
                bus.rsp_src   <= win_idx;
                bus.rsp_route <= win_route;
            end
            if (state == ST_LOOKUP) bus.rsp_accept <= verdict;
            if (state == ST_RESP && bus.rsp_ready) begin
                rr_ptr <= (bus.rsp_src == SRC_W'(N_REQ - 1)) ? '0 : bus.rsp_src + 1'b1;
                if (!bus.rsp_accept && stat_deny_cnt != '1)
                    stat_deny_cnt <= stat_deny_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_gateway_route_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level model of arbitration, table lookup and deny counting.
module tb_gateway_route_arbiter;

    localparam int N_REQ   = 4;
    localparam int N_DESTS = 16;

    logic        aclk       = 1'b0;
    logic        aresetn    = 1'b0;
    logic        cfg_we     = 1'b0;
    logic [3:0]  cfg_dest   = '0;
    logic [3:0]  cfg_sender = '0;
    logic        cfg_en     = 1'b0;
    logic [31:0] stat_deny_cnt;

    gateway_route_arbiter_if #(.N_REQ(N_REQ)) bus ();

    gateway_route_arbiter #(.N_REQ(N_REQ), .N_DESTS(N_DESTS)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_we        (cfg_we),
        .cfg_dest      (cfg_dest),
        .cfg_sender    (cfg_sender),
        .cfg_en        (cfg_en),
        .bus           (bus),
        .stat_deny_cnt (stat_deny_cnt)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL timeout %s: event never occurred, expected within budget (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    bit          m_en  [N_DESTS];
    logic [3:0]  m_snd [N_DESTS];
    int          m_ptr;
    logic [31:0] m_cnt;
    bit          pending;
    int          age;
    int          p_src;
    logic [13:0] p_route;
    logic        p_acc;

    function automatic int pick(input logic [N_REQ-1:0] v, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic model_verdict(input logic [13:0] r);
        int         d;
        logic [3:0] s;
        d = int'(r[13:10]);
        s = r[9:6];
        if (d >= N_DESTS) return 1'b0;
        if (!m_en[d]) return 1'b0;
        return (m_snd[d] == 4'd0) || (s == m_snd[d]) || (s == 4'd0);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < N_DESTS; d++) begin
            m_en[d]  = 1'b0;
            m_snd[d] = 4'd0;
        end
        m_ptr   = 0;
        m_cnt   = '0;
        pending = 1'b0;
        age     = 0;
    endtask

    always @(negedge aclk) begin
        int               g;
        logic [N_REQ-1:0] exp_rdy;
        if (!aresetn) begin
            model_reset();
        end else begin
            chk("deny_cnt", stat_deny_cnt, m_cnt);
            if (!pending) begin
                g       = pick(bus.req_valid, m_ptr);
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;
                chk("req_ready", bus.req_ready, exp_rdy);
                chk("rsp_valid_idle", bus.rsp_valid, 0);
                if (g >= 0) begin
                    pending = 1'b1;
                    age     = 0;
                    p_src   = g;
                    p_route = bus.req_route[g*14 +: 14];
                end
            end else begin
                age++;
                chk("req_ready_busy", bus.req_ready, 0);
                if (age == 1) begin
                    chk("rsp_valid_lookup", bus.rsp_valid, 0);
                    p_acc = model_verdict(p_route);
                end else begin
                    chk("rsp_valid", bus.rsp_valid, 1);
                    chk("rsp_src", bus.rsp_src, p_src);
                    chk("rsp_route", bus.rsp_route, p_route);
                    chk("rsp_dest", bus.rsp_dest, p_route[13:10]);
                    chk("rsp_accept", bus.rsp_accept, p_acc);
                    if (bus.rsp_ready) begin
                        m_ptr = (p_src + 1) % N_REQ;
                        if (!p_acc && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                        pending = 1'b0;
                    end
                end
            end
            if (cfg_we && int'(cfg_dest) < N_DESTS) begin
                m_en[cfg_dest]  = cfg_en;
                m_snd[cfg_dest] = cfg_sender;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [1:0]  last_src;
    logic [13:0] last_route;
    logic [3:0]  last_dest;

    task automatic cfg_write(input logic [3:0] d, input logic [3:0] s, input logic en);
        @(posedge aclk); #1;
        cfg_we = 1'b1; cfg_dest = d; cfg_sender = s; cfg_en = en;
        @(posedge aclk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic wait_grant(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge aclk);
            if (bus.req_ready[i]) ok = 1'b1;
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge aclk);
            if (bus.rsp_valid) ok = 1'b1;
        end
    endtask

    task automatic send(input int i, input logic [13:0] r, input bit lk_wr,
                        input logic [3:0] lk_dest, input logic [3:0] lk_snd, input logic lk_en,
                        output logic acc, output int lat);
        bit ok;
        int t0;
        acc = 1'b0;
        lat = -1;
        @(posedge aclk); #1;
        bus.req_valid[i]          = 1'b1;
        bus.req_route[i*14 +: 14] = r;
        wait_grant(i, ok);
        if (!ok) begin
            fail_timeout("grant");
            bus.req_valid[i] = 1'b0;
        end else begin
            t0 = cyc;
            @(posedge aclk); #1;
            bus.req_valid[i] = 1'b0;
            if (lk_wr) begin
                cfg_we = 1'b1; cfg_dest = lk_dest; cfg_sender = lk_snd; cfg_en = lk_en;
                @(posedge aclk); #1;
                cfg_we = 1'b0;
            end
            wait_rsp(ok);
            if (!ok) begin
                fail_timeout("rsp_valid");
            end else begin
                lat        = cyc - t0;
                acc        = bus.rsp_accept;
                last_src   = bus.rsp_src;
                last_route = bus.rsp_route;
                last_dest  = bus.rsp_dest;
                if (bus.rsp_ready) @(posedge aclk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   lat;
        bit   ok;
        int   gcnt;
        int   gidx [5];
        int   gcyc [5];
        int   exp_order [5];

        exp_order = '{0, 1, 2, 3, 0};
        bus.req_valid = '0;
        bus.req_route = '0;
        bus.rsp_ready = 1'b1;

        // reset values, with a request pending to show req_ready is held low
        @(negedge aclk);
        bus.req_valid = 4'b0100;
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_src", bus.rsp_src, 0);
        chk("rst_rsp_route", bus.rsp_route, 0);
        chk("rst_rsp_dest", bus.rsp_dest, 0);
        chk("rst_rsp_accept", bus.rsp_accept, 0);
        chk("rst_deny_cnt", stat_deny_cnt, 0);
        bus.req_valid = '0;
        @(negedge aclk); #2;
        aresetn = 1'b1;

        // 1: empty table denies
        send(0, {4'd2, 4'd1, 6'h05}, 0, 0, 0, 0, acc, lat);
        chk("t1_latency", lat, 2);
        chk("t1_accept", acc, 0);
        @(negedge aclk);
        chk("t1_deny_cnt", stat_deny_cnt, 1);

        // 2: programmed entry accepts matching sender
        cfg_write(4'd3, 4'd5, 1'b1);
        send(1, 14'h0D6A, 0, 0, 0, 0, acc, lat);
        chk("t2_latency", lat, 2);
        chk("t2_accept", acc, 1);
        chk("t2_dest", last_dest, 3);
        chk("t2_src", last_src, 1);
        chk("t2_route", last_route, 14'h0D6A);

        // 3: sender mismatch, route wildcard, entry wildcard
        send(2, {4'd3, 4'd6, 6'h11}, 0, 0, 0, 0, acc, lat);
        chk("t3_mismatch_accept", acc, 0);
        @(negedge aclk);
        chk("t3_deny_cnt", stat_deny_cnt, 2);
        send(3, {4'd3, 4'd0, 6'h22}, 0, 0, 0, 0, acc, lat);
        chk("t3_route_wild_accept", acc, 1);
        cfg_write(4'd3, 4'd0, 1'b1);
        send(3, {4'd3, 4'd9, 6'h33}, 0, 0, 0, 0, acc, lat);
        chk("t3_entry_wild_accept", acc, 1);

        // 4: all requesters active, pointer starts at 0
        @(posedge aclk); #1;
        bus.req_valid = 4'hF;
        gcnt = 0;
        for (int k = 0; k < 60 && gcnt < 5; k++) begin
            @(negedge aclk);
            if (|bus.req_ready) begin
                gidx[gcnt] = -1;
                for (int j = 0; j < N_REQ; j++) if (bus.req_ready[j]) gidx[gcnt] = j;
                gcyc[gcnt] = cyc;
                gcnt++;
            end
        end
        @(posedge aclk); #1;
        bus.req_valid = '0;
        if (gcnt < 5) fail_timeout("t4_grants");
        else begin
            for (int j = 0; j < 5; j++) chk("t4_order", gidx[j], exp_order[j]);
            for (int j = 1; j < 5; j++) chk("t4_spacing", gcyc[j] - gcyc[j-1], 3);
        end
        repeat (4) @(posedge aclk);

        // 5: consumer back-pressure
        #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid[2] = 1'b1;
        bus.req_route[2*14 +: 14] = {4'd3, 4'd9, 6'h15};
        wait_grant(2, ok);
        if (!ok) fail_timeout("t5_grant");
        @(posedge aclk); #1;
        bus.req_valid[2] = 1'b0;
        bus.req_valid[0] = 1'b1;
        bus.req_route[0 +: 14] = {4'd2, 4'd0, 6'h00};
        wait_rsp(ok);
        if (!ok) fail_timeout("t5_rsp");
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk("t5_hold_valid", bus.rsp_valid, 1);
            chk("t5_hold_route", bus.rsp_route, {4'd3, 4'd9, 6'h15});
            chk("t5_hold_src", bus.rsp_src, 2);
            chk("t5_hold_accept", bus.rsp_accept, 1);
            chk("t5_hold_ready", bus.req_ready, 0);
        end
        @(posedge aclk); #1;
        bus.rsp_ready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("t5_release_valid", bus.rsp_valid, 0);
        chk("t5_release_grant", bus.req_ready, 4'b0001);
        @(posedge aclk); #1;
        bus.req_valid[0] = 1'b0;
        repeat (3) @(posedge aclk);

        // 6a: write during LOOKUP uses the old entry, next check the new one
        cfg_write(4'd4, 4'd0, 1'b1);
        send(1, {4'd4, 4'd7, 6'h01}, 1, 4'd4, 4'd0, 1'b0, acc, lat);
        chk("t6_old_entry_accept", acc, 1);
        send(2, {4'd4, 4'd7, 6'h02}, 0, 0, 0, 0, acc, lat);
        chk("t6_new_entry_accept", acc, 0);

        // 6b: reset while a verdict is waiting
        cfg_write(4'd5, 4'd0, 1'b1);
        @(posedge aclk); #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid[3] = 1'b1;
        bus.req_route[3*14 +: 14] = {4'd5, 4'd2, 6'h3F};
        wait_grant(3, ok);
        if (!ok) fail_timeout("t6_grant");
        @(posedge aclk); #1;
        bus.req_valid[3] = 1'b0;
        wait_rsp(ok);
        if (!ok) fail_timeout("t6_rsp");
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_valid", bus.rsp_valid, 0);
        chk("t6_rst_accept", bus.rsp_accept, 0);
        chk("t6_rst_route", bus.rsp_route, 0);
        chk("t6_rst_deny_cnt", stat_deny_cnt, 0);
        @(negedge aclk); #2;
        aresetn = 1'b1;
        bus.rsp_ready = 1'b1;
        send(3, {4'd5, 4'd2, 6'h3F}, 0, 0, 0, 0, acc, lat);
        chk("t6_retry_accept", acc, 0);
        @(negedge aclk);
        chk("t6_retry_deny_cnt", stat_deny_cnt, 1);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            @(posedge aclk); #1;
            bus.req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N_REQ; i++)
                bus.req_route[i*14 +: 14] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 6'($urandom)};
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            cfg_we        = ($urandom_range(0, 4) == 0);
            cfg_dest      = 4'($urandom_range(0, 15));
            cfg_sender    = 4'($urandom_range(0, 3));
            cfg_en        = ($urandom_range(0, 3) != 0);
        end
        @(posedge aclk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        cfg_we        = 1'b0;
        repeat (6) @(posedge aclk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
